// File: rtl/rx_byte_fifo.sv
// rx_byte_fifo: receive-side first-word-fall-through byte buffer behind the
// UART receiver. Frame-error bytes are counted and discarded. Good bytes that
// arrive while the buffer is full and no pop happens are dropped and raise a
// sticky overflow flag.
module rx_byte_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    input  logic          rx_err,
    input  logic          rd,
    input  logic          clr_ovf,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic [7:0]    err_cnt,
    output logic [15:0]   byte_cnt
);

    localparam logic [AW:0]   LP_FULL    = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   LP_CNT_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] LP_PTR_ONE = {{(AW - 1){1'b0}}, 1'b1};

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_count;
    logic          r_overflow;
    logic [7:0]    r_err_cnt;
    logic [15:0]   r_byte_cnt;

    logic w_good;
    logic w_bad;
    logic w_full;
    logic w_empty;
    logic w_we;
    logic w_re;
    logic w_drop;

    // Accept/drop decisions; a pop on a full buffer frees the slot the
    // incoming byte needs, so a simultaneous write is still accepted.
    always_comb begin
        w_good  = rx_valid & ~rx_err;
        w_bad   = rx_valid & rx_err;
        w_full  = (r_count == LP_FULL);
        w_empty = (r_count == '0);
        w_re    = rd & ~w_empty;
        w_we    = w_good & (~w_full | rd);
        w_drop  = w_good & w_full & ~rd;
    end

    // Storage array and the two wrapping pointers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_mem <= '{default: '0};
            r_wp  <= '0;
            r_rp  <= '0;
        end else begin
            if (w_we) begin
                r_mem[r_wp] <= rx_data;
                r_wp        <= r_wp + LP_PTR_ONE;
            end
            if (w_re) begin
                r_rp <= r_rp + LP_PTR_ONE;
            end
        end
    end

    // Occupancy: moves only when exactly one of write/read is accepted.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
        end else begin
            case ({w_we, w_re})
                2'b10:   r_count <= r_count + LP_CNT_ONE;
                2'b01:   r_count <= r_count - LP_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow (set beats clear), saturating error and wrapping byte counters.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_overflow <= 1'b0;
            r_err_cnt  <= '0;
            r_byte_cnt <= '0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end
            if (w_bad && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
            if (w_we) begin
                r_byte_cnt <= r_byte_cnt + 16'd1;
            end
        end
    end

    // Outputs come from registered state only.
    always_comb begin
        rd_data  = r_mem[r_rp];
        rd_valid = ~w_empty;
        full     = w_full;
        count    = r_count;
        overflow = r_overflow;
        err_cnt  = r_err_cnt;
        byte_cnt = r_byte_cnt;
    end

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Testbench for rx_byte_fifo: a queue-based reference model predicts the
// outputs each cycle; a negedge process compares DUT against it, and directed
// literal checks pin the model at key points.
module tb_rx_byte_fifo;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_err = 1'b0;
    logic        rd = 1'b0;
    logic        clr_ovf = 1'b0;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        full;
    logic [3:0]  count;
    logic        overflow;
    logic [7:0]  err_cnt;
    logic [15:0] byte_cnt;

    rx_byte_fifo #(.DEPTH(8), .AW(3)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_err   (rx_err),
        .rd       (rd),
        .clr_ovf  (clr_ovf),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .full     (full),
        .count    (count),
        .overflow (overflow),
        .err_cnt  (err_cnt),
        .byte_cnt (byte_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    // Reference model state
    logic [7:0] mq [$];
    logic       m_ovf = 1'b0;
    int         m_err = 0;
    int         m_bcnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_err  = 0;
        m_bcnt = 0;
    endtask

    // Next state from the behavioural rules: pop first, then push if room.
    task automatic model_step(input logic [7:0] d, input logic v, input logic e,
                              input logic r, input logic c);
        bit popped = 0;
        bit dropped = 0;
        if (r && mq.size() > 0) begin
            void'(mq.pop_front());
            popped = 1;
        end
        if (v && !e) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(d);
                m_bcnt = (m_bcnt + 1) % 65536;
            end else begin
                dropped = 1;
            end
        end
        if (v && e && m_err < 255) m_err++;
        if (dropped) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
        if (popped) begin end
    endtask

    // One clock: drive at negedge+1, update the model, return just after posedge.
    task automatic step(input logic [7:0] d, input logic v, input logic e,
                        input logic r, input logic c);
        @(negedge clk);
        #1;
        rx_data = d; rx_valid = v; rx_err = e; rd = r; clr_ovf = c;
        model_step(d, v, e, r, c);
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        step(d, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop();
        step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        n_rst = 1'b0;
        rx_data = '0; rx_valid = 0; rx_err = 0; rd = 0; clr_ovf = 0;
        model_reset();
        @(negedge clk);
        #1;
        n_rst = 1'b1;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("count", 32'(count), 32'(mq.size()));
            check("rd_valid", 32'(rd_valid), 32'(mq.size() > 0));
            check("full", 32'(full), 32'(mq.size() == DEPTH));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("err_cnt", 32'(err_cnt), 32'(m_err));
            check("byte_cnt", 32'(byte_cnt), 32'(m_bcnt));
            if (mq.size() > 0) check("rd_data", 32'(rd_data), 32'(mq[0]));
        end
    end

    logic [7:0] drain3 [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h55};

    initial begin
        #2;
        check("reset_rd_data", 32'(rd_data), 32'h00);
        check("reset_rd_valid", 32'(rd_valid), 32'h0);
        check("reset_count", 32'(count), 32'h0);
        model_reset();
        @(negedge clk);
        #1;
        n_rst = 1'b1;
        chk_en = 1'b1;

        // Basic push then pop
        push(8'h41); push(8'h42); push(8'h43);
        check("t1_count", 32'(count), 32'd3);
        check("t1_head", 32'(rd_data), 32'h41);
        pop();
        check("t1_pop1", 32'(rd_data), 32'h42);
        pop();
        check("t1_pop2", 32'(rd_data), 32'h43);
        pop();
        check("t1_empty", 32'(rd_valid), 32'h0);
        check("t1_bytes", 32'(byte_cnt), 32'd3);

        // Fill, overflow, clear
        do_reset();
        for (int i = 0; i < 8; i++) push(8'(i));
        check("t2_full", 32'(full), 32'h1);
        push(8'h08);
        check("t2_ovf", 32'(overflow), 32'h1);
        check("t2_count", 32'(count), 32'd8);
        check("t2_head", 32'(rd_data), 32'h00);
        check("t2_bytes", 32'(byte_cnt), 32'd8);
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t2_clr", 32'(overflow), 32'h0);

        // Simultaneous pop and push on a full buffer
        step(8'h55, 1'b1, 1'b0, 1'b1, 1'b0);
        check("t3_count", 32'(count), 32'd8);
        check("t3_ovf", 32'(overflow), 32'h0);
        for (int i = 0; i < 8; i++) begin
            check("t3_drain", 32'(rd_data), 32'(drain3[i]));
            pop();
        end
        check("t3_empty", 32'(rd_valid), 32'h0);

        // Empty buffer: pop plus push, then pop alone
        step(8'h9A, 1'b1, 1'b0, 1'b1, 1'b0);
        check("t4_count", 32'(count), 32'd1);
        check("t4_head", 32'(rd_data), 32'h9A);
        pop();
        pop();
        check("t4_idle_count", 32'(count), 32'd0);
        check("t4_idle_bytes", 32'(byte_cnt), 32'd10);

        // Error saturation, then set-beats-clear
        do_reset();
        for (int i = 0; i < 260; i++) step(8'hEE, 1'b1, 1'b1, 1'b0, 1'b0);
        check("t5_errsat", 32'(err_cnt), 32'd255);
        check("t5_count", 32'(count), 32'd0);
        check("t5_bytes", 32'(byte_cnt), 32'd0);
        for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
        step(8'h77, 1'b1, 1'b0, 1'b0, 1'b1);
        check("t5_setwins", 32'(overflow), 32'h1);
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t5_cleared", 32'(overflow), 32'h0);

        // Pointer wrap with steady traffic
        do_reset();
        for (int i = 0; i < 4; i++) push(8'(8'hA0 + i));
        check("t6_head", 32'(rd_data), 32'hA0);
        for (int i = 4; i < 20; i++) step(8'(8'hA0 + i), 1'b1, 1'b0, 1'b1, 1'b0);
        check("t6_wraphead", 32'(rd_data), 32'hB0);
        for (int i = 0; i < 4; i++) pop();
        check("t6_empty", 32'(rd_valid), 32'h0);
        check("t6_bytes", 32'(byte_cnt), 32'd20);

        // Asynchronous reset mid-stream
        push(8'hC1); push(8'hC2);
        step(8'hCC, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        rx_valid = 0; rx_err = 0; rd = 0; clr_ovf = 0;
        n_rst = 1'b0;
        #1;
        check("ar_rd_data", 32'(rd_data), 32'h00);
        check("ar_rd_valid", 32'(rd_valid), 32'h0);
        check("ar_count", 32'(count), 32'h0);
        check("ar_err", 32'(err_cnt), 32'h0);
        check("ar_bytes", 32'(byte_cnt), 32'h0);
        check("ar_full", 32'(full), 32'h0);
        model_reset();
        @(negedge clk);
        #1;
        n_rst = 1'b1;
        push(8'h3C);
        check("post_reset_head", 32'(rd_data), 32'h3C);
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rx_byte_fifo.md
# rx_byte_fifo

Receive-side byte buffer that sits directly downstream of the UART receiver. It captures each completed byte from `rx` into an 8-deep first-word-fall-through FIFO so that display and control logic can drain bytes at their own pace, typically one byte per debounced button press. It discards frame-error bytes and maintains a sticky overflow flag, a saturating error counter and a wrapping received-byte counter.

## Interface
- `DEPTH`, 8: FIFO entries; must be a power of two, at least 2.
- `AW`, 3: pointer width; must equal log2(`DEPTH`).
- `clk` in 1: system clock; all state updates on its rising edge.
- `n_rst` in 1: reset, asynchronous and active-low.
- `rx_data` in 8: byte from the receiver; valid only while `rx_valid`=1.
- `rx_valid` in 1: one-cycle pulse per completed frame.
- `rx_err` in 1: frame error (bad stop bit); sampled only while `rx_valid`=1.
- `rd` in 1: one-cycle pop request, e.g. the `edge_detection` output.
- `clr_ovf` in 1: one-cycle clear of `overflow`.
- `rd_data` out 8: head byte, combinational from the head entry; meaningful only when `rd_valid`=1.
- `rd_valid` out 1: FIFO is not empty.
- `full` out 1: `count` == `DEPTH`.
- `count` out AW+1: number of stored bytes, 0..`DEPTH`.
- `overflow` out 1: sticky; set when a good byte is dropped because the FIFO is full.
- `err_cnt` out 8: frame-error count; saturates at 255.
- `byte_cnt` out 16: count of good bytes written; wraps from 65535 to 0.

## Operation
- Storage: `DEPTH` x 8 register array, write pointer `wp`, read pointer `rp`, occupancy `count`. Pointers wrap modulo `DEPTH` (from `DEPTH`-1 to 0).
- Good byte: `rx_valid`=1 and `rx_err`=0.
- Write accept `we`: a good byte arrives and either `full`=0, or `full`=1 and `rd`=1 in the same cycle. On accept: `mem[wp]` takes `rx_data`, `wp` increments and `byte_cnt` increments.
- Drop: a good byte arrives, `full`=1 and `rd`=0. Nothing is written and `overflow` is set. `byte_cnt` does not change.
- Error byte: `rx_valid`=1 and `rx_err`=1. The byte is never stored. `err_cnt` increments unless it is already 255. `overflow` is unaffected.
- Read accept `re`: `rd`=1 and `count`>0. `rp` increments. `rd` on an empty FIFO is ignored and changes no state.
- `count` update:
  - +1 when `we` and not `re`.
  - −1 when `re` and not `we`.
  - Unchanged when both or neither occur.
- Empty FIFO with `rd` and a good byte in the same cycle: the write is accepted and the read is ignored. Next cycle `count`=1.
- Full FIFO with `rd` and a good byte in the same cycle: the head is popped and the new byte is written at the freed slot. `count` stays at `DEPTH` and `overflow` is not set.
- `overflow`: cleared by `clr_ovf`. If a set condition and `clr_ovf` occur in the same cycle, the set wins.
- `rd_data` = `mem[rp]`. The array resets to 0x00, so `rd_data` reads 0x00 out of reset.

## Timing
- Reset (asynchronous, `n_rst`=0), immediate:
  - `wp`=`rp`=0, `count`=0 and all array entries 0x00.
  - `rd_valid`=0, `full`=0, `overflow`=0, `err_cnt`=0, `byte_cnt`=0.
  - `rd_data`=0x00.
- Reset asserted mid-operation discards all stored bytes and counters. The first good byte after release is accepted normally.
- Write latency: a byte accepted at edge N appears on `rd_data`, with `rd_valid`=1, after edge N when the FIFO was empty. Latency is one cycle.
- Read latency: a pop at edge N presents the next entry on `rd_data` after edge N. The FIFO is first-word fall-through, so the head is visible before `rd` is issued.
- `full`, `rd_valid`, `count`, `overflow`, `err_cnt` and `byte_cnt` are registered or derived from registered state. They never depend combinationally on `rx_valid`, `rd` or `clr_ovf`.
- No handshake back to the receiver. `rx_valid` is never stalled; bytes are either accepted or dropped.

## Test plan
- Reset, then push 0x41, 0x42, 0x43 with no reads. Required: `count`=3, `rd_data`=0x41. Then issue three `rd` pulses. Required: `rd_data` steps 0x42, 0x43; finally `rd_valid`=0 and `byte_cnt`=3.
- Fill with 0x00..0x07. Required: `full`=1. Push 0x08 with `rd`=0. Required: `overflow`=1, `count`=8, head still 0x00 and `byte_cnt`=8. Pulse `clr_ovf`. Required: `overflow`=0.
- Full FIFO holding 0x00..0x07, then `rd` and a push of 0x55 in the same cycle. Required: `count`=8, `overflow`=0. Draining yields 0x01..0x07, then 0x55.
- Empty FIFO, then `rd` and a push of 0x9A in the same cycle. Required: `count`=1, `rd_data`=0x9A next cycle. Separately, `rd` alone on an empty FIFO leaves all state unchanged.
- 260 pulses with `rx_err`=1. Required: `err_cnt`=255, `count`=0, `byte_cnt`=0. A cycle with a set condition and `clr_ovf` together leaves `overflow`=1.
- Run 20 pushes and 20 pops so both pointers wrap past 7. Required: data order is preserved across the wrap. Then assert `n_rst` mid-stream. Required: all outputs return to their reset values without waiting for a clock edge.
